// File: rtl/cell_test_pkg.sv
// cell_test_pkg: shared widths, cell ID map, sequencer state encoding and the
// golden model for the LibreSilicon standard-cell test sequencer.
//   cell_n_inputs(id)              -> number of driven inputs (1..4)
//   cell_golden(id, vec, model_bit) -> expected outputs and compare mask
package cell_test_pkg;

    localparam int unsigned ID_W  = 5;
    localparam int unsigned VEC_W = 4;
    localparam int unsigned OUT_W = 2;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned NIN_W = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [ID_W-1:0] CELL_AND2X1  = 5'd0;
    localparam logic [ID_W-1:0] CELL_AND2X2  = 5'd1;
    localparam logic [ID_W-1:0] CELL_AOI21X1 = 5'd2;
    localparam logic [ID_W-1:0] CELL_AOI22X1 = 5'd3;
    localparam logic [ID_W-1:0] CELL_BUFX2   = 5'd4;
    localparam logic [ID_W-1:0] CELL_BUFX4   = 5'd5;
    localparam logic [ID_W-1:0] CELL_CLKBUF1 = 5'd6;
    localparam logic [ID_W-1:0] CELL_HAX1    = 5'd7;
    localparam logic [ID_W-1:0] CELL_INV     = 5'd8;
    localparam logic [ID_W-1:0] CELL_INVX1   = 5'd9;
    localparam logic [ID_W-1:0] CELL_INVX2   = 5'd10;
    localparam logic [ID_W-1:0] CELL_INVX4   = 5'd11;
    localparam logic [ID_W-1:0] CELL_INVX8   = 5'd12;
    localparam logic [ID_W-1:0] CELL_LATCH   = 5'd13;
    localparam logic [ID_W-1:0] CELL_MUX2X1  = 5'd14;
    localparam logic [ID_W-1:0] CELL_NAND2X1 = 5'd15;
    localparam logic [ID_W-1:0] CELL_NAND3X1 = 5'd16;
    localparam logic [ID_W-1:0] CELL_NOR2X1  = 5'd17;
    localparam logic [ID_W-1:0] CELL_NOR3X1  = 5'd18;
    localparam logic [ID_W-1:0] CELL_OAI21X1 = 5'd19;
    localparam logic [ID_W-1:0] CELL_OAI22X1 = 5'd20;
    localparam logic [ID_W-1:0] CELL_OR2X1   = 5'd21;
    localparam logic [ID_W-1:0] CELL_OR2X2   = 5'd22;
    localparam logic [ID_W-1:0] CELL_TBUFX1  = 5'd23;
    localparam logic [ID_W-1:0] CELL_TBUFX2  = 5'd24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    // Expected cell response and per-bit compare enable (1 = compare).
    typedef struct packed {
        logic [OUT_W-1:0] expected;
        logic [OUT_W-1:0] mask;
    } golden_t;

    // Number of inputs exercised per cell; unknown IDs default to one.
    function automatic logic [NIN_W-1:0] cell_n_inputs(input logic [ID_W-1:0] id);
        logic [NIN_W-1:0] n;
        case (id)
            CELL_AND2X1, CELL_AND2X2, CELL_HAX1, CELL_LATCH,
            CELL_NAND2X1, CELL_NOR2X1, CELL_OR2X1, CELL_OR2X2,
            CELL_TBUFX1, CELL_TBUFX2:                          n = 3'd2;
            CELL_AOI21X1, CELL_MUX2X1, CELL_NAND3X1,
            CELL_NOR3X1, CELL_OAI21X1:                         n = 3'd3;
            CELL_AOI22X1, CELL_OAI22X1:                        n = 3'd4;
            default:                                           n = 3'd1;
        endcase
        return n;
    endfunction

    // Golden response for one vector. LATCH with CLK=0 returns the model bit;
    // whether that bit is trustworthy yet is decided by the caller.
    function automatic golden_t cell_golden(input logic [ID_W-1:0]  id,
                                            input logic [VEC_W-1:0] vec,
                                            input logic             model_bit);
        golden_t g;
        logic a, b, c, d;
        a = vec[0];
        b = vec[1];
        c = vec[2];
        d = vec[3];
        g.expected = '0;
        g.mask     = 2'b01;
        case (id)
            CELL_AND2X1, CELL_AND2X2:              g.expected[0] = a & b;
            CELL_AOI21X1:                          g.expected[0] = ~((a & b) | c);
            CELL_AOI22X1:                          g.expected[0] = ~((a & b) | (c & d));
            CELL_BUFX2, CELL_BUFX4, CELL_CLKBUF1:  g.expected[0] = a;
            CELL_HAX1: begin
                g.expected = {a & b, a ^ b};
                g.mask     = 2'b11;
            end
            CELL_INV, CELL_INVX1, CELL_INVX2,
            CELL_INVX4, CELL_INVX8:                g.expected[0] = ~a;
            CELL_LATCH:                            g.expected[0] = b ? a : model_bit;
            CELL_MUX2X1:                           g.expected[0] = c ? b : a;
            CELL_NAND2X1:                          g.expected[0] = ~(a & b);
            CELL_NAND3X1:                          g.expected[0] = ~(a & b & c);
            CELL_NOR2X1:                           g.expected[0] = ~(a | b);
            CELL_NOR3X1:                           g.expected[0] = ~(a | b | c);
            CELL_OAI21X1:                          g.expected[0] = ~((a | b) & c);
            CELL_OAI22X1:                          g.expected[0] = ~((a | b) & (c | d));
            CELL_OR2X1, CELL_OR2X2:                g.expected[0] = a | b;
            CELL_TBUFX1, CELL_TBUFX2: begin
                // Output floats while EN=0, so only enabled vectors count.
                g.expected[0] = a;
                g.mask        = {1'b0, b};
            end
            default:                               g.mask = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/cell_out_sync.sv
// cell_out_sync: two-flop synchroniser for the raw asynchronous cell outputs.
//   clk, rst_n : clock, async active-low reset
//   d          : raw cell outputs
//   q          : synchronised outputs (two cycles of latency)
module cell_out_sync #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cell_test_sequencer.sv
// cell_test_sequencer: walks every input vector of one selected test cell,
// waits SETTLE_CYCLES, samples the synchronised outputs and compares them
// against the golden model, reporting error count and first failing vector.
//   wb_clk_i, wb_rst_n : clock, async active-low reset
//   start, abort       : run control; cell_sel sampled with start
//   cell_id_o, cell_in : selected cell ID and input drive to the array
//   cell_out           : raw cell outputs from the array
//   busy, done, pass, illegal, err_count, fail_vec, fail_valid : status
module cell_test_sequencer
    import cell_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned NUM_CELLS     = 25
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [ID_W-1:0]  cell_sel,
    output logic [ID_W-1:0]  cell_id_o,
    output logic [VEC_W-1:0] cell_in,
    input  logic [OUT_W-1:0] cell_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             illegal,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] fail_vec,
    output logic             fail_valid
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [ID_W-1:0]  cell_id_nxt;
    logic [VEC_W-1:0] cell_in_nxt;
    logic             busy_nxt, done_nxt, pass_nxt, illegal_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic [VEC_W-1:0] fail_vec_nxt;
    logic             fail_valid_nxt;
    logic [VEC_W-1:0] vec_q, vec_nxt;
    logic [CNT_W-1:0] settle_cnt, settle_nxt;
    logic             model_bit, model_bit_nxt;
    logic             model_valid, model_valid_nxt;
    logic             illegal_pend, illegal_pend_nxt;

    logic [OUT_W-1:0] out_sync;
    logic [NIN_W-1:0] n_in;
    logic [VEC_W-1:0] last_vec;
    golden_t          golden;
    logic [OUT_W-1:0] cmp_mask;
    logic             mismatch;

    cell_out_sync #(.WIDTH(OUT_W)) u_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .d     (cell_out),
        .q     (out_sync)
    );

    // Golden comparison of the currently applied vector.
    always_comb begin
        n_in     = cell_n_inputs(cell_id_o);
        last_vec = VEC_W'((5'd1 << n_in) - 5'd1);
        golden   = cell_golden(cell_id_o, vec_q, model_bit);
        cmp_mask = golden.mask;
        // LATCH hold vectors mean nothing until a transparent vector has set Q.
        if (cell_id_o == CELL_LATCH && !vec_q[1] && !model_valid) begin
            cmp_mask = '0;
        end
        mismatch = |((out_sync ^ golden.expected) & cmp_mask);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt        = state;
        cell_id_nxt      = cell_id_o;
        cell_in_nxt      = cell_in;
        pass_nxt         = pass;
        illegal_nxt      = illegal;
        err_nxt          = err_count;
        fail_vec_nxt     = fail_vec;
        fail_valid_nxt   = fail_valid;
        vec_nxt          = vec_q;
        settle_nxt       = settle_cnt;
        model_bit_nxt    = model_bit;
        model_valid_nxt  = model_valid;
        illegal_pend_nxt = illegal_pend;
        busy_nxt         = 1'b0;
        done_nxt         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (illegal_pend) begin
                    // Illegal IDs spend one cycle here so done lands two cycles after start.
                    illegal_pend_nxt = 1'b0;
                    state_nxt        = ST_FIN;
                end else if (start) begin
                    cell_id_nxt     = cell_sel;
                    err_nxt         = '0;
                    fail_valid_nxt  = 1'b0;
                    pass_nxt        = 1'b0;
                    model_valid_nxt = 1'b0;
                    vec_nxt         = '0;
                    cell_in_nxt     = '0;
                    if (32'(cell_sel) >= NUM_CELLS) begin
                        illegal_nxt      = 1'b1;
                        illegal_pend_nxt = 1'b1;
                    end else begin
                        illegal_nxt = 1'b0;
                        state_nxt   = ST_APPLY;
                    end
                end
            end
            ST_APPLY: begin
                settle_nxt = '0;
                state_nxt  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = ST_CHECK;
                end else begin
                    settle_nxt = settle_cnt + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_count != '1) begin
                        err_nxt = err_count + ERR_W'(1);
                    end
                    if (!fail_valid) begin
                        fail_vec_nxt   = vec_q;
                        fail_valid_nxt = 1'b1;
                    end
                end
                if (cell_id_o == CELL_LATCH && vec_q[1]) begin
                    model_bit_nxt   = vec_q[0];
                    model_valid_nxt = 1'b1;
                end
                if (vec_q == last_vec) begin
                    cell_in_nxt = '0;
                    state_nxt   = ST_FIN;
                end else begin
                    vec_nxt     = vec_q + VEC_W'(1);
                    cell_in_nxt = vec_q + VEC_W'(1);
                    state_nxt   = ST_APPLY;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                cell_in_nxt = '0;
                state_nxt   = ST_IDLE;
            end
        endcase

        // Abort discards the in-flight vector's result and skips done.
        if (abort && (state == ST_APPLY || state == ST_SETTLE || state == ST_CHECK)) begin
            state_nxt      = ST_IDLE;
            cell_in_nxt    = '0;
            err_nxt        = err_count;
            fail_vec_nxt   = fail_vec;
            fail_valid_nxt = fail_valid;
        end

        busy_nxt = (state_nxt == ST_APPLY) || (state_nxt == ST_SETTLE) ||
                   (state_nxt == ST_CHECK);
        if (state_nxt == ST_FIN) begin
            done_nxt = 1'b1;
            pass_nxt = (err_nxt == '0) && !illegal_nxt;
        end
    end

    // State and registered outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state        <= ST_IDLE;
            cell_id_o    <= '0;
            cell_in      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            illegal      <= 1'b0;
            err_count    <= '0;
            fail_vec     <= '0;
            fail_valid   <= 1'b0;
            vec_q        <= '0;
            settle_cnt   <= '0;
            model_bit    <= 1'b0;
            model_valid  <= 1'b0;
            illegal_pend <= 1'b0;
        end else begin
            state        <= state_nxt;
            cell_id_o    <= cell_id_nxt;
            cell_in      <= cell_in_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            pass         <= pass_nxt;
            illegal      <= illegal_nxt;
            err_count    <= err_nxt;
            fail_vec     <= fail_vec_nxt;
            fail_valid   <= fail_valid_nxt;
            vec_q        <= vec_nxt;
            settle_cnt   <= settle_nxt;
            model_bit    <= model_bit_nxt;
            model_valid  <= model_valid_nxt;
            illegal_pend <= illegal_pend_nxt;
        end
    end

endmodule

// File: doc/cell_test_sequencer.md
# cell_test_sequencer

Sequencer that exhaustively exercises one selected standard cell on the LibreSilicon test wafer. It drives the cell's inputs through every vector, waits for settling, samples the synchronised outputs and compares them against a built-in golden model. It sits between the Caravel user-project logic-analyser/Wishbone control registers and the per-cell input fan-out and output mux of the cell array.

## Interface
- `SETTLE_CYCLES`, default 4: wait cycles per vector; legal range 2..15.
- `NUM_CELLS`, default 25: number of cell IDs; IDs ≥ NUM_CELLS are illegal.

Ports:
- `wb_clk_i` in 1: clock.
- `wb_rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a run; honoured only in IDLE.
- `abort` in 1: terminate a run.
- `cell_sel` in 5: cell ID to test; sampled with `start`.
- `cell_id_o` out 5: registered ID driving the external output mux and input enables.
- `cell_in` out 4: cell input drive; bit0=A, 1=B, 2=C, 3=D.
- `cell_out` in 2: raw (asynchronous) cell outputs; bit0=Y/YS/Q, bit1=YC.
- `busy` out 1: high in APPLY/SETTLE/CHECK.
- `done` out 1: one-cycle pulse at end of a completed run.
- `pass` out 1: valid from `done` until the next `start`; 1 iff `err_count`==0 and ID legal.
- `illegal` out 1: selected ID ≥ NUM_CELLS.
- `err_count` out 8: mismatching vectors; saturates at 255.
- `fail_vec` out 4: vector index of first mismatch.
- `fail_valid` out 1: `fail_vec` holds a captured value.

## Operation
- Cell IDs, in order 0..24: AND2X1, AND2X2, AOI21X1, AOI22X1, BUFX2, BUFX4, CLKBUF1, HAX1, INV, INVX1, INVX2, INVX4, INVX8, LATCH, MUX2X1, NAND2X1, NAND3X1, NOR2X1, NOR3X1, OAI21X1, OAI22X1, OR2X1, OR2X2, TBUFX1, TBUFX2.
- Input count n per cell from the package: 1, 2, 3 or 4. Vectors run 0 .. 2^n−1 ascending; the vector value drives `cell_in[n-1:0]`, and unused bits are 0.
- Pin mapping exceptions:
  - MUX2X1: A=bit0, B=bit1, S=bit2; Y = S ? B : A.
  - LATCH: D=bit0, CLK=bit1.
  - TBUF: A=bit0, EN=bit1.
- Golden functions:
  - AOI21 Y=~(A&B|C); AOI22 Y=~(A&B|C&D).
  - OAI21 Y=~((A|B)&C); OAI22 Y=~((A|B)&(C|D)).
  - HAX1: YS=A^B, YC=A&B.
  - Bit1 is compared only for HAX1.
- Masking:
  - TBUF vectors with EN=0 are not compared; the output is Z.
  - LATCH uses a model bit. CLK=1 gives expected Q=D and sets the model bit to D and `model_valid`=1. CLK=0 gives expected Q=model bit. Vectors are masked while `model_valid`=0, which is cleared at `start`.
- FSM:
  - IDLE: on `start`, latch `cell_sel` and clear `err_count`, `fail_valid`, `pass` and `model_valid`.
    - Legal ID → APPLY.
    - Illegal ID → FIN with `illegal`=1 and `pass`=0.
  - APPLY (1 cycle): drive the vector → SETTLE.
  - SETTLE (SETTLE_CYCLES cycles) → CHECK.
  - CHECK (1 cycle): compare the synchronised output under the mask. On mismatch, increment `err_count` (saturating); if `fail_valid`=0, capture `fail_vec` and set `fail_valid`. Last vector → FIN; otherwise next vector → APPLY.
  - FIN (1 cycle): `done`=1 and `pass` updated → IDLE.
- `abort` while busy: next state IDLE, `cell_in`←0, no `done`, `err_count`/`fail_*` hold. `abort` in IDLE/FIN is ignored.
- `start` while not in IDLE is ignored. Simultaneous `start`+`abort` in IDLE: `start` wins.
- `cell_in` holds its vector through SETTLE and CHECK, and returns to 0 in FIN/IDLE.

## Timing
- Reset values:
  - IDLE state.
  - `cell_in`=0, `cell_id_o`=0.
  - `busy`=0, `done`=0, `pass`=0, `illegal`=0.
  - `err_count`=0, `fail_vec`=0, `fail_valid`=0.
- Reset during a run returns all outputs to reset values immediately (async).
- `cell_out` passes through a 2-flop synchroniser every cycle. SETTLE_CYCLES ≥ 2 guarantees CHECK sees data launched at APPLY.
- Per vector: SETTLE_CYCLES+2 cycles. Legal run: `done` asserts 2^n·(SETTLE_CYCLES+2)+1 cycles after the `start` edge.
- Illegal ID: `done` asserts 2 cycles after `start`.

## Structure
- Package `cell_test_pkg`:
  - cell ID localparams.
  - `cell_n_inputs(id)`.
  - `cell_golden(id, vec, model_bit)` returning expected[1:0] and mask[1:0].
  - state enum typedef.
- Sub-module `cell_out_sync`: 2-bit, 2-flop synchroniser with the same async active-low reset.

## Test plan
- INV (8), SETTLE=4, ideal cell model: `done` at cycle 13; `pass`=1, `err_count`=0.
- NAND2X1 with model output stuck at 1: `err_count`=1, `fail_vec`=3, `pass`=0.
- HAX1 with YC stuck at 0: `err_count`=1, `fail_vec`=3.
- LATCH, ideal model: first two vectors masked, `pass`=1.
- TBUFX1 with output forced X when EN=0: vectors 0,1 ignored, `pass`=1.
- `cell_sel`=27: `illegal`=1, `done` at cycle 2, `pass`=0.
- Abort during the third vector of AOI22X1: IDLE next cycle, `cell_in`=0, no `done`.
- `wb_rst_n` low mid-run: outputs at reset values.
